iir_deemph: RTL and testbench

- De-emphasis IIR stage directly downstream of the L+R audio low-pass FIR (decimated by 8).
- Pops one audio sample per operation from the FIR's output FIFO and computes a first-order IIR: fixed coefficients, 10-bit quantization.
- Pushes each result into the next stage's input FIFO.
- Uses FIFO-side handshakes on both ports: first-word-fall-through read side, write side with full flag.

---
 rtl/iir_deemph_if.sv | 32 +++
 rtl/iir_deemph.sv | 108 ++++++++++
 tb/tb_iir_deemph.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iir_deemph_if.sv
// FIFO-side handshake bundle for the de-emphasis stage: FWFT read port upstream,
// write port with full flag downstream.
interface iir_deemph_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] din;
    logic                  in_empty;
    logic                  in_rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  out_full;
    logic                  out_wr_en;

    // The filter drives the pop/push strobes and the result.
    modport master (
        input  din,
        input  in_empty,
        input  out_full,
        output in_rd_en,
        output dout,
        output out_wr_en
    );

    // FIFO side of the same wires.
    modport slave (
        output din,
        output in_empty,
        output out_full,
        input  in_rd_en,
        input  dout,
        input  out_wr_en
    );
endinterface

// File: rtl/iir_deemph.sv
// First-order de-emphasis IIR: y[n] = deq(X0*x[n]) + deq(X1*x[n-1]) + deq(Y1*y[n-1]),
// one sample per IDLE -> MUL -> SUM -> WRITE pass.
module iir_deemph #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned QUANT_BITS = 10,
    parameter int          X0_COEFF   = 178,
    parameter int          X1_COEFF   = 178,
    parameter int          Y1_COEFF   = -667
) (
    input logic         clock,
    input logic         reset,
    iir_deemph_if.master bus
);
    localparam int unsigned PW = 2 * DATA_WIDTH;

    localparam logic signed [PW-1:0] CoefX0 = PW'(X0_COEFF);
    localparam logic signed [PW-1:0] CoefX1 = PW'(X1_COEFF);
    localparam logic signed [PW-1:0] CoefY1 = PW'(Y1_COEFF);
    localparam logic signed [PW-1:0] RoundAdj = {{(PW - QUANT_BITS){1'b0}}, {QUANT_BITS{1'b1}}};

    typedef enum logic [1:0] {StIdle, StMul, StSum, StWrite} state_e;

    state_e                  state_q, state_d;
    logic signed [DATA_WIDTH-1:0] x_cur_q, x_cur_d;
    logic signed [DATA_WIDTH-1:0] x_prev_q, x_prev_d;
    logic signed [DATA_WIDTH-1:0] y_prev_q, y_prev_d;
    logic signed [DATA_WIDTH-1:0] dout_q, dout_d;
    logic signed [PW-1:0]    p0_q, p0_d;
    logic signed [PW-1:0]    p1_q, p1_d;
    logic signed [PW-1:0]    p2_q, p2_d;
    logic                    rd_en;
    logic                    wr_en;

    // Divide by 2^QUANT_BITS rounding toward zero, then truncate to the sample width.
    function automatic logic signed [DATA_WIDTH-1:0] deq(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] adj;
        adj = p[PW-1] ? (p + RoundAdj) : p;
        return DATA_WIDTH'(adj >>> QUANT_BITS);
    endfunction

    always_comb begin
        state_d  = state_q;
        x_cur_d  = x_cur_q;
        x_prev_d = x_prev_q;
        y_prev_d = y_prev_q;
        dout_d   = dout_q;
        p0_d     = p0_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!bus.in_empty) begin
                    rd_en   = 1'b1;
                    x_cur_d = bus.din;
                    state_d = StMul;
                end
            end
            StMul: begin
                p0_d    = CoefX0 * PW'(x_cur_q);
                p1_d    = CoefX1 * PW'(x_prev_q);
                p2_d    = CoefY1 * PW'(y_prev_q);
                state_d = StSum;
            end
            StSum: begin
                dout_d  = deq(p0_q) + deq(p1_q) + deq(p2_q);
                state_d = StWrite;
            end
            StWrite: begin
                // History advances only once the result has actually been pushed.
                if (!bus.out_full) begin
                    wr_en    = 1'b1;
                    x_prev_d = x_cur_q;
                    y_prev_d = dout_q;
                    state_d  = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            x_cur_q  <= '0;
            x_prev_q <= '0;
            y_prev_q <= '0;
            dout_q   <= '0;
            p0_q     <= '0;
            p1_q     <= '0;
            p2_q     <= '0;
        end else begin
            state_q  <= state_d;
            x_cur_q  <= x_cur_d;
            x_prev_q <= x_prev_d;
            y_prev_q <= y_prev_d;
            dout_q   <= dout_d;
            p0_q     <= p0_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
        end
    end

    // Strobes are masked while reset is held so nothing is popped during reset.
    assign bus.in_rd_en  = rd_en & ~reset;
    assign bus.out_wr_en = wr_en & ~reset;
    assign bus.dout      = dout_q;
endmodule

// File: tb/tb_iir_deemph.sv
// Directed bench for iir_deemph: behavioural FIFOs on both sides, hand-computed
// vectors, plus a random-gap run checked against a division-based model.
module tb_iir_deemph;
    logic clock;
    logic reset;
    int   tests;
    int   failed;
    logic gap_en;
    logic pop_pending;

    logic signed [31:0] up_q[$];
    logic signed [31:0] out_q[$];
    logic signed [31:0] rnd_x[$];
    logic signed [31:0] rnd_y[$];

    iir_deemph_if #(.DATA_WIDTH(32)) bus ();

    iir_deemph #(
        .DATA_WIDTH(32),
        .QUANT_BITS(10),
        .X0_COEFF  (178),
        .X1_COEFF  (178),
        .Y1_COEFF  (-667)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Upstream FWFT FIFO: pop just after the edge that saw in_rd_en.
    initial begin
        bus.in_empty = 1'b1;
        bus.din      = '0;
        forever begin
            @(posedge clock);
            #1;
            if (pop_pending && up_q.size() > 0) void'(up_q.pop_front());
            bus.in_empty = (up_q.size() == 0) || (gap_en && ($urandom_range(0, 1) == 1));
            bus.din      = (up_q.size() > 0) ? up_q[0] : '0;
        end
    end

    // Downstream FIFO capture and handshake invariants, sampled mid-cycle.
    always @(negedge clock) begin
        if (!reset) begin
            tests++;
            assert (!(bus.in_rd_en === 1'b1 && bus.in_empty === 1'b1)) else begin
                failed++;
                $error("FAIL rd_while_empty: got in_rd_en=1 in_empty=1, expected no pop");
            end
            tests++;
            assert (!(bus.in_rd_en === 1'b1 && bus.out_wr_en === 1'b1)) else begin
                failed++;
                $error("FAIL rd_wr_overlap: got both strobes high, expected at most one");
            end
        end
        pop_pending = bus.in_rd_en;
        if (bus.out_wr_en === 1'b1) out_q.push_back(bus.dout);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for n outputs, then confirm no extra writes trail in.
    task automatic wait_outs(input int n, input string tag);
        int cyc;
        cyc = 0;
        while (out_q.size() < n && cyc < 3000) begin
            @(negedge clock);
            cyc++;
        end
        repeat (8) @(negedge clock);
        tests++;
        assert (out_q.size() == n) else begin
            failed++;
            $error("FAIL %s_count: got %0d outputs, expected %0d", tag, out_q.size(), n);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset        = 1'b1;
        bus.out_full = 1'b0;
        gap_en       = 1'b0;
        up_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        out_q.delete();
    endtask

    function automatic logic signed [31:0] mdeq(input longint p);
        return 32'(p / 1024);
    endfunction

    initial begin
        logic signed [31:0] xp;
        logic signed [31:0] yp;
        logic signed [31:0] y;
        logic signed [31:0] held;
        int                 cyc;
        tests        = 0;
        failed       = 0;
        gap_en       = 1'b0;
        pop_pending  = 1'b0;
        reset        = 1'b1;
        bus.out_full = 1'b0;

        // Reset state, with a sample already waiting upstream.
        up_q.push_back(32'sd1024);
        repeat (3) @(negedge clock);
        check("reset_dout", bus.dout, 32'sd0);
        check_bit("reset_rd_en", bus.in_rd_en, 1'b0);
        check_bit("reset_wr_en", bus.out_wr_en, 1'b0);
        reset = 1'b0;

        // Impulse.
        up_q.push_back(32'sd0);
        up_q.push_back(32'sd0);
        wait_outs(3, "impulse");
        if (out_q.size() == 3) begin
            check("impulse_y0", out_q[0], 32'sd178);
            check("impulse_y1", out_q[1], 32'sd63);
            check("impulse_y2", out_q[2], -32'sd41);
        end
        check("idle_dout_hold", bus.dout, -32'sd41);

        // Step.
        do_reset();
        for (int i = 0; i < 3; i++) up_q.push_back(32'sd1024);
        wait_outs(3, "step");
        if (out_q.size() == 3) begin
            check("step_y0", out_q[0], 32'sd178);
            check("step_y1", out_q[1], 32'sd241);
            check("step_y2", out_q[2], 32'sd200);
        end

        // Sign symmetry and toward-zero truncation.
        do_reset();
        up_q.push_back(-32'sd1024);
        up_q.push_back(32'sd0);
        wait_outs(2, "neg");
        if (out_q.size() == 2) begin
            check("neg_y0", out_q[0], -32'sd178);
            check("neg_y1", out_q[1], -32'sd63);
        end
        do_reset();
        up_q.push_back(32'sd6);
        wait_outs(1, "pos6");
        if (out_q.size() == 1) check("pos6_y0", out_q[0], 32'sd1);
        do_reset();
        up_q.push_back(-32'sd6);
        wait_outs(1, "neg6");
        if (out_q.size() == 1) check("neg6_y0", out_q[0], -32'sd1);
        do_reset();
        up_q.push_back(32'sd1);
        wait_outs(1, "one");
        if (out_q.size() == 1) check("one_y0", out_q[0], 32'sd0);

        // Backpressure: first result stalls in WRITE, the rest wait upstream.
        do_reset();
        bus.out_full = 1'b1;
        for (int i = 0; i < 3; i++) up_q.push_back(32'sd1024);
        repeat (5) @(negedge clock);
        held = bus.dout;
        check("bp_dout_first", held, 32'sd178);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check_bit("bp_wr_en", bus.out_wr_en, 1'b0);
            check_bit("bp_rd_en", bus.in_rd_en, 1'b0);
            check("bp_dout_stable", bus.dout, 32'sd178);
        end
        check("bp_no_writes", 32'(out_q.size()), 32'sd0);
        bus.out_full = 1'b0;
        wait_outs(3, "bp");
        if (out_q.size() == 3) begin
            check("bp_y0", out_q[0], 32'sd178);
            check("bp_y1", out_q[1], 32'sd241);
            check("bp_y2", out_q[2], 32'sd200);
        end

        // Random input gaps over 100 samples against a division-based model.
        do_reset();
        xp = '0;
        yp = '0;
        rnd_x.delete();
        rnd_y.delete();
        for (int i = 0; i < 100; i++) begin
            logic signed [31:0] x;
            x = (i % 3 == 0) ? $urandom() : 32'($signed(16'($urandom())));
            y = mdeq(longint'(178) * longint'(x)) + mdeq(longint'(178) * longint'(xp))
              + mdeq(longint'(-667) * longint'(yp));
            rnd_x.push_back(x);
            rnd_y.push_back(y);
            xp = x;
            yp = y;
        end
        gap_en = 1'b1;
        foreach (rnd_x[i]) up_q.push_back(rnd_x[i]);
        wait_outs(100, "gaps");
        gap_en = 1'b0;
        if (out_q.size() == 100) begin
            foreach (rnd_y[i]) check($sformatf("gaps_y%0d", i), out_q[i], rnd_y[i]);
        end

        // Reset while a sample is in SUM: dropped, history cleared.
        do_reset();
        up_q.push_back(32'sd1024);
        wait_outs(1, "mid_pre");
        up_q.push_back(32'sd5000);
        cyc = 0;
        while (bus.in_rd_en !== 1'b1 && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        check_bit("mid_pop_seen", bus.in_rd_en, 1'b1);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("mid_dout_zero", bus.dout, 32'sd0);
        check_bit("mid_wr_en", bus.out_wr_en, 1'b0);
        check_bit("mid_rd_en", bus.in_rd_en, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        check("mid_no_write", 32'(out_q.size()), 32'sd1);
        up_q.push_back(32'sd1024);
        wait_outs(2, "mid_post");
        if (out_q.size() == 2) check("mid_post_y0", out_q[1], 32'sd178);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
